prefetch_op_scheduler: RTL

- Sits directly upstream of the prefetcher data queue (`prefetcherData`). It is the only source of that block's `reqOpcode`/`reqAddr`/`reqData`/`reqLast`.
- Arbitrates four event sources into at most one queue opcode per cycle: DDR read beats, NVDLA read requests, promise readout toward NVDLA, and predictor prefetch candidates.
- Forwards queue misses and prefetches to DDR as AR requests, tracks outstanding DDR reads, and registers the NVDLA R channel.

---
 rtl/prefetch_op_scheduler_pkg.sv | 23 ++
 rtl/prefetch_op_scheduler_axi_slot_reg.sv | 37 +++
 rtl/prefetch_op_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/prefetch_op_scheduler_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the prefetcher
// scheduler and the data queue it feeds.
package prefetcher_pkg;

    typedef enum logic [2:0] {
        OP_NONE              = 3'd0,
        OP_READ_REQ_PREF     = 3'd1,
        OP_READ_REQ_MASTER   = 3'd2,
        OP_READ_DATA_SLAVE   = 3'd3,
        OP_READ_DATA_PROMISE = 3'd4
    } opcode_t;

    localparam logic [2:0] ERR_NONE            = 3'd0;
    localparam logic [2:0] ERR_QUEUE_OVERFLOW  = 3'd1;
    localparam logic [2:0] ERR_QUEUE_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_PROTOCOL        = 3'd3;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ERR = 1'b1
    } sched_state_t;

endpackage

// File: rtl/prefetch_op_scheduler_axi_slot_reg.sv
// One-entry valid/ready holding register for an AXI AR request (address + len).
// While en is low the entry is frozen: nothing loads and nothing drains.
module axi_slot_reg #(
    parameter int ADDR_BITS = 64,
    parameter int LEN_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [LEN_BITS-1:0]  load_len,
    input  logic                 ready,
    output logic                 valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [LEN_BITS-1:0]  len
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            len   <= '0;
        end else if (en) begin
            // A load wins over a drain, so an entry can be replaced on the
            // same edge the previous one is handed off.
            if (load) begin
                valid <= 1'b1;
                addr  <= load_addr;
                len   <= load_len;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prefetch_op_scheduler.sv
// Arbitrates DDR beats, NVDLA reads, promise readout and prefetch candidates
// into one queue opcode per cycle; issues DDR ARs and drives the NVDLA R channel.
module prefetch_op_scheduler
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int LOG_BLOCK_DATA_BYTES = 3,
    parameter int BURST_LEN_WIDTH      = 4,
    parameter int MAX_OUTSTANDING      = 4,
    localparam int DATA_BITS           = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BURST_LEN_WIDTH-1:0] crs_burstLen,
    input  logic                       m_ar_valid,
    output logic                       m_ar_ready,
    input  logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic                       m_r_valid,
    input  logic                       m_r_ready,
    output logic [DATA_BITS-1:0]       m_r_data,
    output logic                       m_r_last,
    input  logic                       pf_valid,
    output logic                       pf_ready,
    input  logic [ADDR_BITS-1:0]       pf_addr,
    output logic                       s_ar_valid,
    input  logic                       s_ar_ready,
    output logic [ADDR_BITS-1:0]       s_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic                       s_r_valid,
    output logic                       s_r_ready,
    input  logic [DATA_BITS-1:0]       s_r_data,
    input  logic                       s_r_last,
    output logic [2:0]                 reqOpcode,
    output logic [ADDR_BITS-1:0]       reqAddr,
    output logic [DATA_BITS-1:0]       reqData,
    output logic                       reqLast,
    output logic [BURST_LEN_WIDTH-1:0] reqBurstLen,
    input  logic                       addrHit,
    input  logic                       pr_r_valid,
    input  logic [DATA_BITS-1:0]       respData,
    input  logic                       respLast,
    input  logic                       almostFull,
    input  logic [2:0]                 errorCode,
    output logic                       sched_err
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    sched_state_t          state, state_next;
    opcode_t               op;
    logic                  run;
    logic                  slot_valid, slot_load, slot_free, can_issue;
    logic [ADDR_BITS-1:0]  slot_load_addr;
    logic                  promise_grant;
    logic [CNT_W-1:0]      outstanding;
    logic                  cnt_inc, cnt_dec, cnt_fault;

    assign run         = (state == ST_RUN);
    assign sched_err   = (state == ST_ERR);
    assign reqOpcode   = op;
    assign reqBurstLen = crs_burstLen;
    assign s_r_ready   = run;
    assign s_ar_valid  = slot_valid && run;

    // The slot entry is counted as in flight so that refilling it on a drain
    // edge can never push the counter past its cap.
    assign slot_free = !slot_valid || s_ar_ready;
    assign can_issue = slot_free &&
        (({1'b0, outstanding} + (CNT_W+1)'(slot_valid)) < (CNT_W+1)'(MAX_OUTSTANDING));

    always_comb begin
        op             = OP_NONE;
        reqAddr        = '0;
        reqData        = '0;
        reqLast        = 1'b0;
        m_ar_ready     = 1'b0;
        pf_ready       = 1'b0;
        slot_load      = 1'b0;
        slot_load_addr = '0;
        promise_grant  = 1'b0;
        if (run) begin
            if (s_r_valid) begin
                op      = OP_READ_DATA_SLAVE;
                reqData = s_r_data;
                reqLast = s_r_last;
            end else if (m_ar_valid) begin
                // A stalled miss still owns the cycle; lower sources wait.
                reqAddr = m_ar_addr;
                if (addrHit || can_issue) begin
                    op             = OP_READ_REQ_MASTER;
                    m_ar_ready     = 1'b1;
                    slot_load      = !addrHit;
                    slot_load_addr = m_ar_addr;
                end
            end else if (pr_r_valid && (!m_r_valid || m_r_ready)) begin
                op            = OP_READ_DATA_PROMISE;
                promise_grant = 1'b1;
            end else if (pf_valid && !almostFull && can_issue) begin
                op             = OP_READ_REQ_PREF;
                reqAddr        = pf_addr;
                pf_ready       = 1'b1;
                slot_load      = 1'b1;
                slot_load_addr = pf_addr;
            end
        end
    end

    axi_slot_reg #(
        .ADDR_BITS (ADDR_BITS),
        .LEN_BITS  (BURST_LEN_WIDTH)
    ) u_ar_slot (
        .clk       (clk),
        .reset     (reset),
        .en        (run),
        .load      (slot_load),
        .load_addr (slot_load_addr),
        .load_len  (crs_burstLen),
        .ready     (s_ar_ready),
        .valid     (slot_valid),
        .addr      (s_ar_addr),
        .len       (s_ar_len)
    );

    assign cnt_inc   = s_ar_valid && s_ar_ready;
    assign cnt_dec   = s_r_valid && s_r_ready && s_r_last;
    assign cnt_fault = (cnt_inc && !cnt_dec && outstanding == CNT_W'(MAX_OUTSTANDING)) ||
                       (cnt_dec && !cnt_inc && outstanding == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else if (!cnt_fault) begin
            if (cnt_inc && !cnt_dec)      outstanding <= outstanding + 1'b1;
            else if (cnt_dec && !cnt_inc) outstanding <= outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_r_valid <= 1'b0;
            m_r_data  <= '0;
            m_r_last  <= 1'b0;
        end else if (promise_grant) begin
            m_r_valid <= 1'b1;
            m_r_data  <= respData;
            m_r_last  <= respLast;
        end else if (m_r_ready) begin
            m_r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_RUN && (errorCode != ERR_NONE || cnt_fault))
            state_next = ST_ERR;
    end

endmodule
